// File: rtl/fft_sequencer_if.sv
// rtl/fft_sequencer_if.sv - butterfly issue and write-back sequencing bus
interface fft_sequencer_if #(
    parameter int N_LOG2 = 6
);
    localparam int STAGE_W = $clog2(N_LOG2 + 1);

    logic                start;
    logic                hold;
    logic                busy;
    logic                done;
    logic [STAGE_W-1:0]  stage;
    logic                rd_valid;
    logic [N_LOG2-1:0]   addr_a;
    logic [N_LOG2-1:0]   addr_b;
    logic [N_LOG2-2:0]   twiddle_address;
    logic                wb_valid;
    logic [N_LOG2-1:0]   wb_addr_a;
    logic [N_LOG2-1:0]   wb_addr_b;

    modport master (
        input  start, hold,
        output busy, done, stage, rd_valid, addr_a, addr_b, twiddle_address,
               wb_valid, wb_addr_a, wb_addr_b
    );

    modport slave (
        output start, hold,
        input  busy, done, stage, rd_valid, addr_a, addr_b, twiddle_address,
               wb_valid, wb_addr_a, wb_addr_b
    );
endinterface

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - radix-2 FFT butterfly address sequencer with fixed-latency write-back tracking
module fft_sequencer #(
    parameter int N_LOG2       = 6,
    parameter int BFLY_LATENCY = 4
) (
    input  logic            clock,
    input  logic            reset,
    fft_sequencer_if.master bus
);
    localparam int                     STAGE_W    = $clog2(N_LOG2 + 1);
    localparam int                     JW         = N_LOG2 - 1;
    localparam logic [JW-1:0]          J_LAST     = '1;
    localparam logic [STAGE_W-1:0]     STAGE_LAST = STAGE_W'(N_LOG2 - 1);
    // Oldest pipeline slot retires this cycle, so only the younger slots count as pending.
    localparam logic [BFLY_LATENCY-1:0] PEND_MASK = {BFLY_LATENCY{1'b1}} >> 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [JW-1:0]           j;
    logic [BFLY_LATENCY-1:0] pipe_valid;
    logic [N_LOG2-1:0]       pipe_a [BFLY_LATENCY];
    logic [N_LOG2-1:0]       pipe_b [BFLY_LATENCY];

    logic                    issue;
    logic                    pending;
    logic [JW-1:0]           pos;
    logic [JW-1:0]           tw_next;
    logic [STAGE_W-1:0]      tw_shift;
    logic [N_LOG2-1:0]       span;
    logic [N_LOG2-1:0]       grp;
    logic [N_LOG2-1:0]       a_next;
    logic [N_LOG2-1:0]       b_next;

    always_comb begin
        issue    = (state == ISSUE) && !bus.hold;
        pending  = |(pipe_valid & PEND_MASK);
        span     = N_LOG2'(1) << bus.stage;
        pos      = j & ~({JW{1'b1}} << bus.stage);
        grp      = {1'b0, j} >> bus.stage;
        a_next   = (grp << (bus.stage + STAGE_W'(1))) | {1'b0, pos};
        b_next   = a_next | span;
        tw_shift = STAGE_LAST - bus.stage;
        tw_next  = pos << tw_shift;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            j                   <= '0;
            bus.stage           <= '0;
            bus.busy            <= 1'b0;
            bus.done            <= 1'b0;
            bus.rd_valid        <= 1'b0;
            bus.addr_a          <= '0;
            bus.addr_b          <= '0;
            bus.twiddle_address <= '0;
            bus.wb_valid        <= 1'b0;
            bus.wb_addr_a       <= '0;
            bus.wb_addr_b       <= '0;
            pipe_valid          <= '0;
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                pipe_a[i] <= '0;
                pipe_b[i] <= '0;
            end
        end else begin
            bus.done     <= 1'b0;
            bus.rd_valid <= issue;
            if (issue) begin
                bus.addr_a          <= a_next;
                bus.addr_b          <= b_next;
                bus.twiddle_address <= tw_next;
            end

            // Write-back shadow of each issue; advances regardless of hold.
            pipe_valid[0] <= issue;
            pipe_a[0]     <= a_next;
            pipe_b[0]     <= b_next;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
            end
            bus.wb_valid <= pipe_valid[BFLY_LATENCY-1];
            if (pipe_valid[BFLY_LATENCY-1]) begin
                bus.wb_addr_a <= pipe_a[BFLY_LATENCY-1];
                bus.wb_addr_b <= pipe_b[BFLY_LATENCY-1];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= ISSUE;
                        bus.stage <= '0;
                        j         <= '0;
                        bus.busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        j <= j + JW'(1);
                        if (j == J_LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        if (bus.stage == STAGE_LAST) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state     <= ISSUE;
                            bus.stage <= bus.stage + STAGE_W'(1);
                            j         <= '0;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
